// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads a combinational instruction memory and buffers one
// word toward decode over valid/ready. Optional stop-on-zero-word behaviour under FETCH_HALT_EN.
module instr_fetch #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic [AW-1:0] o_pc,
    input  logic [DW-1:0] i_instr,
    output logic          o_ir_valid,
    input  logic          i_ir_ready,
    output logic [DW-1:0] o_ir_instr,
    output logic [AW-1:0] o_ir_pc,
    input  logic          i_br_valid,
    input  logic [AW-1:0] i_br_target,
    output logic          o_halted
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ir_pc;
    logic [DW-1:0] r_ir_instr;
    logic          r_ir_valid;
    logic          r_halted;
    logic          w_take;

    // Buffer can accept a new word when empty or when decode drains it this edge.
    assign w_take = !r_ir_valid || i_ir_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= BOOT;
            r_pc       <= '0;
            r_ir_pc    <= '0;
            r_ir_instr <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= FETCH;
                FETCH: begin
                    if (i_br_valid) begin
                        // Redirect flushes the buffer even if decode is taking it now.
                        r_pc       <= i_br_target;
                        r_ir_valid <= 1'b0;
                    end else if (w_take) begin
`ifdef FETCH_HALT_EN
                        if (i_instr == '0) begin
                            r_halted   <= 1'b1;
                            r_state    <= HALT;
                            r_ir_valid <= 1'b0;
                        end else begin
                            r_ir_instr <= i_instr;
                            r_ir_pc    <= r_pc;
                            r_ir_valid <= 1'b1;
                            r_pc       <= r_pc + 1'b1;
                        end
`else
                        r_ir_instr <= i_instr;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        r_pc       <= r_pc + 1'b1;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    if (r_ir_valid && i_ir_ready)
                        r_ir_valid <= 1'b0;
                end
`endif
                default: r_state <= BOOT;
            endcase
        end
    end

    assign o_pc       = r_pc;
    assign o_ir_valid = r_ir_valid;
    assign o_ir_instr = r_ir_instr;
    assign o_ir_pc    = r_ir_pc;
`ifdef FETCH_HALT_EN
    assign o_halted   = r_halted;
`else
    assign o_halted   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a preloaded combinational instruction memory.
module tb_instr_fetch;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          ir_valid;
    logic          ir_ready = 1'b1;
    logic [DW-1:0] ir_instr;
    logic [AW-1:0] ir_pc;
    logic          br_valid = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic          halted;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign instr = mem[pc];

    instr_fetch #(.AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_reset(rst_n), .o_pc(pc), .i_instr(instr),
        .o_ir_valid(ir_valid), .i_ir_ready(ir_ready), .o_ir_instr(ir_instr),
        .o_ir_pc(ir_pc), .i_br_valid(br_valid), .i_br_target(br_target), .o_halted(halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; the next edge is the first (BOOT) edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1+AW+DW+AW+1-1:0] got;
        got = {ir_valid, ir_pc, ir_instr, pc, halted};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
        tick();
        do_reset();
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_w [4] = '{32'h200, 32'h201, 32'h204, 32'h108};
        tick();
        checks++;
        if ({ir_valid, pc} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL boot_edge valid=%b pc=%0d exp valid=0 pc=0", ir_valid, pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, exp_w[i], 5'(i), 5'(i + 1)}) begin
                errors++;
                $display("FAIL stream_%0d valid=%b instr=%h ir_pc=%0d pc=%0d exp 1/%h/%0d/%0d",
                         i, ir_valid, ir_instr, ir_pc, pc, exp_w[i], i, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick(); tick();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, 32'h201, 5'd1, 5'd2}) begin
                errors++;
                $display("FAIL stall_%0d valid=%b instr=%h ir_pc=%0d pc=%0d exp 1/00000201/1/2",
                         i, ir_valid, ir_instr, ir_pc, pc);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, 32'h204, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL stall_release instr=%h ir_pc=%0d pc=%0d exp 00000204/2/3",
                     ir_instr, ir_pc, pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        br_valid = 1'b1; br_target = 5'd7;
        tick();
        checks++;
        if ({ir_valid, pc} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL br_in_boot valid=%b pc=%0d exp 0/0", ir_valid, pc);
        end
        br_valid = 1'b0; ir_ready = 1'b0;
        tick();
        checks++;
        if ({ir_valid, ir_instr, pc} !== {1'b1, 32'h200, 5'd1}) begin
            errors++;
            $display("FAIL br_pending valid=%b instr=%h pc=%0d exp 1/00000200/1", ir_valid, ir_instr, pc);
        end
        br_valid = 1'b1; br_target = 5'd3;
        tick();
        checks++;
        if ({ir_valid, pc} !== {1'b0, 5'd3}) begin
            errors++;
            $display("FAIL br_flush valid=%b pc=%0d exp 0/3", ir_valid, pc);
        end
        br_valid = 1'b0;
        tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, 32'h108, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL br_target_fetch valid=%b instr=%h ir_pc=%0d pc=%0d exp 1/00000108/3/4",
                     ir_valid, ir_instr, ir_pc, pc);
        end
        // Redirect while decode accepts: the pending word is dropped, not replaced.
        ir_ready = 1'b1; br_valid = 1'b1; br_target = 5'd1;
        tick();
        checks++;
        if ({ir_valid, pc} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL br_with_ready valid=%b pc=%0d exp 0/1", ir_valid, pc);
        end
        br_valid = 1'b0;
        tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc} !== {1'b1, 32'h201, 5'd1}) begin
            errors++;
            $display("FAIL br_with_ready_fetch instr=%h ir_pc=%0d exp 00000201/1", ir_instr, ir_pc);
        end
    endtask

`ifndef FETCH_HALT_EN
    task automatic test_wrap();
        ir_ready = 1'b1; br_valid = 1'b1; br_target = 5'd31;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, 32'h0, 5'd31, 5'd0}) begin
            errors++;
            $display("FAIL wrap_31 valid=%b instr=%h ir_pc=%0d pc=%0d exp 1/00000000/31/0",
                     ir_valid, ir_instr, ir_pc, pc);
        end
        tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc, pc} !== {1'b1, 32'h200, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL wrap_0 valid=%b instr=%h ir_pc=%0d pc=%0d exp 1/00000200/0/1",
                     ir_valid, ir_instr, ir_pc, pc);
        end
    endtask
`else
    task automatic test_halt();
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({ir_valid, ir_instr, halted} !== {1'b1, 32'h108, 1'b0}) begin
            errors++;
            $display("FAIL halt_last_word valid=%b instr=%h halted=%b exp 1/00000108/0", ir_valid, ir_instr, halted);
        end
        tick();
        checks++;
        if ({halted, pc, ir_valid} !== {1'b1, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL halt_enter halted=%b pc=%0d valid=%b exp 1/4/0", halted, pc, ir_valid);
        end
        br_valid = 1'b1; br_target = 5'd1;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if ({halted, pc, ir_valid} !== {1'b1, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL halt_br_ignored halted=%b pc=%0d valid=%b exp 1/4/0", halted, pc, ir_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({halted, pc} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL halt_reset halted=%b pc=%0d exp 0/0", halted, pc);
        end
        tick();
        do_reset();
        tick(); tick();
        checks++;
        if ({ir_valid, ir_instr, ir_pc} !== {1'b1, 32'h200, 5'd0}) begin
            errors++;
            $display("FAIL halt_restart instr=%h ir_pc=%0d exp 00000200/0", ir_instr, ir_pc);
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        ir_ready = 1'b1;
        tick(); tick(); tick();
        ir_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ir_valid, pc, ir_instr} !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%b pc=%0d instr=%h exp 0/0/00000000", ir_valid, pc, ir_instr);
        end
        ir_ready = 1'b1;
        tick();
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'h200; mem[1] = 32'h201; mem[2] = 32'h204; mem[3] = 32'h108;
        #3;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
`ifndef FETCH_HALT_EN
        test_wrap();
`else
        test_halt();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
